cpu_debug_ocimem_ctrl: RTL and testbench
========================================

// Module: cpu_debug_ocimem_ctrl
// PURPOSE
//  Sequences on-chip-instruction-memory (OCI RAM/register) accesses for the CPU JTAG debug slave.
//  Consumes the sysclk-domain take_action_ocimem_a/_b and take_no_action_ocimem_a strobes plus jdo.
//  Drives a single-outstanding req/ready memory port with address auto-increment and a timeout.
//  Returns MonDReg/monitor_ready/monitor_error to the debug slave's TCK-side capture path.
// PARAMETERS
//  ADDR_W     8    word-address width of OCI memory; MonAReg wraps modulo 2**ADDR_W
//  TIMEOUT    255  max cycles mem_req may stay unacknowledged before abort (>=1)
//  TO_W       8    timeout counter width, $clog2(TIMEOUT+1)
// PORTS
//  clk                      in   1       system clock
//  reset_n                  in   1       async active-low reset
//  jdo                      in   38      JTAG data-out snapshot, valid while any strobe is high
//  take_action_ocimem_a     in   1       1-cycle: load address; jdo[17]=1 also starts a read
//  take_no_action_ocimem_a  in   1       1-cycle: read at MonAReg, then post-increment
//  take_action_ocimem_b     in   1       1-cycle: write jdo[34:3] at MonAReg, then post-increment
//  mem_req                  out  1       access request, held until mem_ready or timeout
//  mem_we                   out  1       1=write, 0=read; stable while mem_req
//  mem_addr                 out  ADDR_W  word address; stable while mem_req
//  mem_wdata                out  32      write data; stable while mem_req
//  mem_ready                in   1       access complete (same-cycle with mem_req)
//  mem_rdata                in   32      read data, valid with mem_ready on reads
//  mem_err                  in   1       slave error, sampled with mem_ready
//  MonDReg                  out  32      last read data / echoed write data
//  monitor_ready            out  1       high when no access pending and result valid
//  monitor_error            out  1       last access errored or timed out
//  cmd_overrun              out  1       1-cycle pulse: strobe arrived while busy, dropped
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, MonAReg=0, MonDReg=0, mem_req=0, mem_we=0,
//   mem_wdata=0, timeout cnt=0, monitor_ready=1, monitor_error=0, cmd_overrun=0.
//  FSM states IDLE, ISSUE, WAIT, DONE.
//  IDLE: ocimem_a: MonAReg<=jdo[ADDR_W+2:3]; if jdo[17] ->ISSUE (read at new addr, no incr), else stay.
//   no_action_a -> ISSUE read at MonAReg; action_b -> ISSUE write, mem_wdata<=jdo[34:3].
//   Any accepted access clears monitor_ready and monitor_error in the same edge.
//  Strobe priority if several high in one cycle: action_b > ocimem_a > no_action_a; losers dropped
//   and cmd_overrun pulses.
//  ISSUE (1 cycle): mem_req<=1, counter<=0 -> WAIT. Latency: strobe at edge N, mem_req high after N+1.
//  WAIT: mem_req held. mem_ready=1: reads MonDReg<=mem_rdata; writes MonDReg<=mem_wdata;
//   monitor_error<=mem_err; mem_req<=0 -> DONE. Else counter++ ; counter==TIMEOUT-1 without
//   ready: mem_req<=0, monitor_error<=1, MonDReg unchanged -> DONE.
//  DONE (1 cycle): monitor_ready<=1; MonAReg<=MonAReg+1 (wraps 2**ADDR_W-1 -> 0) for
//   no_action_a and action_b only, also after error/timeout; -> IDLE.
//  Best case strobe -> monitor_ready high = 4 edges (ISSUE, WAIT w/ ready, DONE).
//  Any strobe in ISSUE/WAIT/DONE: ignored, cmd_overrun pulses exactly one cycle, state untouched.
//  mem_ready outside WAIT: ignored. mem_addr = MonAReg at all times.
// STRUCTURE
//  Package cpu_debug_ocimem_pkg: state enum (IDLE/ISSUE/WAIT/DONE), jdo field constants
//   (JDO_RDFLAG=17, JDO_DATA_LSB=3, JDO_DATA_MSB=34, JDO_ADDR_LSB=3).
//  One sub-module: cpu_debug_ocimem_timeout (clear/enable counter, TO_W wide, expire flag).
// TESTING
//  Reset release: all outputs at reset values; monitor_ready=1, mem_req=0.
//  ocimem_a jdo addr=0x10, jdo[17]=1; mem_ready 2 cycles later, rdata=0xDEADBEEF -> MonDReg=0xDEADBEEF,
//   MonAReg stays 0x10, monitor_error=0.
//  Three action_b writes from addr 0xFE -> mem_addr 0xFE,0xFF,0x00 (wrap), MonDReg echoes last data.
//  mem_ready never asserted -> mem_req drops after TIMEOUT cycles, monitor_error=1, address incremented.
//  Strobe during WAIT -> cmd_overrun single pulse, mem_addr/mem_wdata unchanged; action_b+no_action_a
//   same cycle in IDLE -> write issued, cmd_overrun=1.
//  reset_n low mid-WAIT -> mem_req=0 immediately (async), FSM IDLE; next command runs normally.

Source files
------------

// File: rtl/cpu_debug_ocimem_pkg.sv
// cpu_debug_ocimem_pkg: shared FSM state type and jdo field positions for the OCI memory controller
package cpu_debug_ocimem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int JDO_RDFLAG   = 17;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_ADDR_LSB = 3;
endpackage

// File: rtl/cpu_debug_ocimem_timeout.sv
// cpu_debug_ocimem_timeout: clear/enable wait counter with expire flag at TIMEOUT-1
//   clk, reset_n  : clock, async active-low reset
//   i_clr, i_en   : synchronous clear (priority) and count enable
//   o_expire      : counter has reached TIMEOUT-1
module cpu_debug_ocimem_timeout #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  logic [TO_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_expire = r_cnt == TO_W'(TIMEOUT - 1);
endmodule

// File: rtl/cpu_debug_ocimem_ctrl.sv
// cpu_debug_ocimem_ctrl: sequences JTAG debug OCI memory accesses over a single-outstanding req/ready port
//   clk, reset_n                         : clock, async active-low reset
//   jdo, take_*                          : debug-slave command strobes and their data snapshot
//   mem_req/we/addr/wdata, mem_ready/rdata/err : memory port
//   MonDReg, monitor_ready, monitor_error, cmd_overrun : status back to the debug slave
module cpu_debug_ocimem_ctrl
  import cpu_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              cmd_overrun
);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_wdata, r_dreg;
  logic r_req, r_we, r_incr, r_rdy, r_err, r_ovr;
  logic w_a, w_na, w_b, w_idle, w_any, w_multi, w_start, w_expire, w_finish;
  logic w_unused;
  assign w_a  = take_action_ocimem_a;
  assign w_na = take_no_action_ocimem_a;
  assign w_b  = take_action_ocimem_b;
  assign w_idle  = r_state == IDLE;
  assign w_any   = w_a | w_na | w_b;
  assign w_multi = (w_a & w_na) | (w_a & w_b) | (w_na & w_b);
  // ocimem_a outranks no_action_a, so an address load without the read flag starts nothing
  assign w_start  = w_idle & (w_b | (w_a ? jdo[JDO_RDFLAG] : w_na));
  assign w_finish = (r_state == WAIT) & (mem_ready | w_expire);
  assign w_unused = &{1'b0, jdo[37:35], jdo[2:0]};
  cpu_debug_ocimem_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (r_state == ISSUE),
    .i_en     (r_state == WAIT),
    .o_expire (w_expire)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = w_finish ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_dreg  <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_incr  <= 1'b0;
      r_rdy   <= 1'b1;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_any & (~w_idle | w_multi);
      if (w_idle) begin
        if (w_b) begin
          r_we    <= 1'b1;
          r_incr  <= 1'b1;
          r_wdata <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        end else if (w_a) begin
          r_we   <= 1'b0;
          r_incr <= 1'b0;
          r_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
        end else if (w_na) begin
          r_we   <= 1'b0;
          r_incr <= 1'b1;
        end
        if (w_start) begin
          r_rdy <= 1'b0;
          r_err <= 1'b0;
        end
      end
      if (r_state == ISSUE) r_req <= 1'b1;
      if (w_finish) begin
        r_req <= 1'b0;
        r_err <= mem_ready ? mem_err : 1'b1;
        if (mem_ready) r_dreg <= r_we ? r_wdata : mem_rdata;
      end
      // post-increment applies even when the access errored or timed out
      if (r_state == DONE) begin
        r_rdy <= 1'b1;
        if (r_incr) r_addr <= r_addr + 1'b1;
      end
    end
  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign MonDReg       = r_dreg;
  assign monitor_ready = r_rdy;
  assign monitor_error = r_err;
  assign cmd_overrun   = r_ovr;
endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// tb_cpu_debug_ocimem_ctrl: self-checking bench for cpu_debug_ocimem_ctrl
module tb_cpu_debug_ocimem_ctrl;
  localparam int TIMEOUT = 255;
  logic clk, reset_n;
  logic [37:0] jdo;
  logic take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic mem_req, mem_we, mem_ready, mem_err;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, MonDReg;
  logic monitor_ready, monitor_error, cmd_overrun;
  int n_pass = 0, n_tot = 0;

  cpu_debug_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .cmd_overrun(cmd_overrun)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic acc; logic early; logic stable; logic ovr;
    logic [7:0] baddr; logic we; logic [31:0] wd; int reqcyc;
  } obs_t;

  typedef struct {
    int kind; logic [7:0] a; logic rdf; logic [31:0] wd; int dly; logic [31:0] rd; logic er;
    logic e_acc; logic [7:0] e_baddr; logic e_we; int e_cyc; logic [31:0] e_dreg; logic e_err; logic [7:0] e_next;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  // kind: 0=take_action_ocimem_a, 1=take_no_action_ocimem_a, 2=take_action_ocimem_b
  function automatic logic [37:0] mkjdo(int kind, logic [7:0] a, logic rdf, logic [31:0] wd);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    if (kind == 0) begin
      j[10:3] = a;
      j[17] = rdf;
    end
    if (kind == 2) j[34:3] = wd;
    return j;
  endfunction

  // Issues one command and plays the memory slave; dly<0 never acknowledges
  task automatic do_cmd(input int kind, input logic [37:0] j, input int dly,
                        input logic [31:0] rd, input logic er, output obs_t o);
    o = '{acc: 0, early: 0, stable: 1, ovr: 0, baddr: 0, we: 0, wd: 0, reqcyc: 0};
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    step();
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    jdo = 38'({$urandom(), $urandom()});
    o.ovr = cmd_overrun;
    o.acc = !monitor_ready;
    if (o.acc) begin
      o.early = mem_req;
      step();
      o.baddr = mem_addr; o.we = mem_we; o.wd = mem_wdata;
      for (int c = 0; c < 400 && mem_req; c++) begin
        if (mem_addr !== o.baddr || mem_we !== o.we || mem_wdata !== o.wd) o.stable = 0;
        o.ovr |= cmd_overrun;
        o.reqcyc++;
        if (c == dly) begin
          mem_ready = 1; mem_rdata = rd; mem_err = er;
        end
        step();
        mem_ready = 0; mem_rdata = $urandom; mem_err = 1'($urandom);
      end
      for (int c = 0; c < 4 && !monitor_ready; c++) step();
    end
  endtask

  vec_t tbl[10];
  logic [31:0] mem_model[256];
  obs_t o;
  logic [7:0] m_addr, a0;
  logic [31:0] m_dreg, wd0;
  logic m_err;

  initial begin
    tbl[0] = '{0, 8'h10, 1, 32'h0,        1, 32'hDEADBEEF, 0, 1, 8'h10, 0, 2,       32'hDEADBEEF, 0, 8'h10};
    tbl[1] = '{0, 8'hFE, 0, 32'h0,        0, 32'h0,        0, 0, 8'h00, 0, 0,       32'hDEADBEEF, 0, 8'hFE};
    tbl[2] = '{2, 8'h00, 0, 32'h11111111, 0, 32'h0,        0, 1, 8'hFE, 1, 1,       32'h11111111, 0, 8'hFF};
    tbl[3] = '{2, 8'h00, 0, 32'h22222222, 2, 32'h0,        0, 1, 8'hFF, 1, 3,       32'h22222222, 0, 8'h00};
    tbl[4] = '{2, 8'h00, 0, 32'h33333333, 0, 32'h0,        0, 1, 8'h00, 1, 1,       32'h33333333, 0, 8'h01};
    tbl[5] = '{1, 8'h00, 0, 32'h0,        3, 32'hCAFEF00D, 1, 1, 8'h01, 0, 4,       32'hCAFEF00D, 1, 8'h02};
    tbl[6] = '{1, 8'h00, 0, 32'h0,        0, 32'h12345678, 0, 1, 8'h02, 0, 1,       32'h12345678, 0, 8'h03};
    tbl[7] = '{0, 8'h7F, 1, 32'h0,        0, 32'hA5A5A5A5, 1, 1, 8'h7F, 0, 1,       32'hA5A5A5A5, 1, 8'h7F};
    tbl[8] = '{1, 8'h00, 0, 32'h0,       -1, 32'h0,        0, 1, 8'h7F, 0, TIMEOUT, 32'hA5A5A5A5, 1, 8'h80};
    tbl[9] = '{2, 8'h00, 0, 32'hFFFF0000, 1, 32'h0,        1, 1, 8'h80, 1, 2,       32'hFFFF0000, 1, 8'h81};

    reset_n = 0; jdo = 0; mem_ready = 0; mem_rdata = 0; mem_err = 0;
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    do_reset();
    chk("rst_monitor_ready", monitor_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_MonDReg", MonDReg, 0);
    chk("rst_monitor_error", monitor_error, 0);
    chk("rst_cmd_overrun", cmd_overrun, 0);

    foreach (tbl[i]) begin
      do_cmd(tbl[i].kind, mkjdo(tbl[i].kind, tbl[i].a, tbl[i].rdf, tbl[i].wd), tbl[i].dly, tbl[i].rd, tbl[i].er, o);
      chk($sformatf("v%0d_access", i), o.acc, tbl[i].e_acc);
      if (tbl[i].e_acc) begin
        chk($sformatf("v%0d_issue_latency", i), o.early, 0);
        chk($sformatf("v%0d_bus_addr", i), o.baddr, tbl[i].e_baddr);
        chk($sformatf("v%0d_bus_we", i), o.we, tbl[i].e_we);
        chk($sformatf("v%0d_req_cycles", i), o.reqcyc, tbl[i].e_cyc);
        chk($sformatf("v%0d_bus_stable", i), o.stable, 1);
        if (tbl[i].e_we) chk($sformatf("v%0d_bus_wdata", i), o.wd, tbl[i].wd);
      end
      chk($sformatf("v%0d_overrun", i), o.ovr, 0);
      chk($sformatf("v%0d_monitor_ready", i), monitor_ready, 1);
      chk($sformatf("v%0d_MonDReg", i), MonDReg, tbl[i].e_dreg);
      chk($sformatf("v%0d_monitor_error", i), monitor_error, tbl[i].e_err);
      chk($sformatf("v%0d_next_addr", i), mem_addr, tbl[i].e_next);
    end

    // strobe while an access is in WAIT is dropped with a single overrun pulse
    jdo = 38'({$urandom(), $urandom()});
    take_no_action_ocimem_a = 1;
    step();
    take_no_action_ocimem_a = 0;
    step();
    a0 = mem_addr; wd0 = mem_wdata;
    chk("ovr_wait_addr", a0, 8'h81);
    jdo = mkjdo(2, 0, 0, 32'h77777777);
    take_action_ocimem_b = 1;
    step();
    take_action_ocimem_b = 0;
    chk("ovr_pulse", cmd_overrun, 1);
    chk("ovr_req_held", mem_req, 1);
    chk("ovr_addr_kept", mem_addr, a0);
    chk("ovr_wdata_kept", mem_wdata, wd0);
    chk("ovr_we_kept", mem_we, 0);
    step();
    chk("ovr_pulse_end", cmd_overrun, 0);
    mem_ready = 1; mem_rdata = 32'h0BADF00D; mem_err = 0;
    step();
    mem_ready = 0;
    step();
    chk("ovr_done_ready", monitor_ready, 1);
    chk("ovr_done_dreg", MonDReg, 32'h0BADF00D);
    chk("ovr_done_addr", mem_addr, 8'h82);

    // simultaneous action_b and no_action_a: the write wins
    jdo = mkjdo(2, 0, 0, 32'h5A5A5A5A);
    take_action_ocimem_b = 1; take_no_action_ocimem_a = 1;
    step();
    take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    chk("dual_overrun", cmd_overrun, 1);
    chk("dual_busy", monitor_ready, 0);
    step();
    chk("dual_req", mem_req, 1);
    chk("dual_we", mem_we, 1);
    chk("dual_wdata", mem_wdata, 32'h5A5A5A5A);
    chk("dual_addr", mem_addr, 8'h82);
    chk("dual_overrun_end", cmd_overrun, 0);
    mem_ready = 1; mem_err = 0;
    step();
    mem_ready = 0;
    step();
    chk("dual_dreg", MonDReg, 32'h5A5A5A5A);
    chk("dual_next_addr", mem_addr, 8'h83);

    // asynchronous reset in the middle of WAIT
    take_no_action_ocimem_a = 1;
    step();
    take_no_action_ocimem_a = 0;
    step();
    chk("arst_req_before", mem_req, 1);
    #2 reset_n = 0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_ready", monitor_ready, 1);
    chk("arst_addr", mem_addr, 0);
    chk("arst_dreg", MonDReg, 0);
    @(posedge clk);
    #1 reset_n = 1;
    do_cmd(2, mkjdo(2, 0, 0, 32'hC0FFEE00), 0, 0, 0, o);
    chk("arst_next_req_cycles", o.reqcyc, 1);
    chk("arst_next_bus_addr", o.baddr, 0);
    chk("arst_next_dreg", MonDReg, 32'hC0FFEE00);
    chk("arst_next_addr", mem_addr, 1);

    // randomized commands against a transaction-level model
    do_reset();
    m_addr = 0; m_dreg = 0; m_err = 0;
    foreach (mem_model[i]) mem_model[i] = $urandom;
    for (int it = 0; it < 40; it++) begin
      int kind, dly;
      logic [7:0] a, tgt;
      logic rdf, er, acc, wr, inc;
      logic [31:0] wd;
      kind = $urandom_range(0, 2);
      a = 8'($urandom); rdf = 1'($urandom); wd = $urandom;
      dly = $urandom_range(0, 4); er = ($urandom_range(0, 3) == 0);
      if (kind == 0) m_addr = a;
      acc = (kind != 0) || rdf;
      wr = (kind == 2);
      inc = (kind != 0);
      tgt = m_addr;
      do_cmd(kind, mkjdo(kind, a, rdf, wd), dly, mem_model[tgt], er, o);
      if (acc) begin
        if (wr) mem_model[tgt] = wd;
        m_dreg = wr ? wd : mem_model[tgt];
        m_err = er;
        m_addr = m_addr + 8'(inc);
      end
      chk($sformatf("r%0d_access", it), o.acc, acc);
      if (acc) begin
        chk($sformatf("r%0d_bus_addr", it), o.baddr, tgt);
        chk($sformatf("r%0d_bus_we", it), o.we, wr);
        chk($sformatf("r%0d_req_cycles", it), o.reqcyc, dly + 1);
        chk($sformatf("r%0d_bus_stable", it), o.stable, 1);
      end
      chk($sformatf("r%0d_monitor_ready", it), monitor_ready, 1);
      chk($sformatf("r%0d_MonDReg", it), MonDReg, m_dreg);
      chk($sformatf("r%0d_monitor_error", it), monitor_error, m_err);
      chk($sformatf("r%0d_next_addr", it), mem_addr, m_addr);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
